// File: rtl/mul_seq.sv
// mul_seq: iterative radix-2 shift-add multiplier (MUL/UMULL/SMULL).
// Ports: clk, reset, start, a, b, MulOp in; busy, done, Result, Result2, MulFlags out.
module mul_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   MulOp,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Result,
  output logic [N-1:0] Result2,
  output logic [3:0]   MulFlags
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   mcand;
  logic [N-1:0]     mplier;
  logic [CW-1:0]    cnt;
  logic             sgn;
  logic             wide;

  logic             is_smull;
  logic             is_wide;
  logic [N-1:0]     a_mag;
  logic [N-1:0]     b_mag;
  logic [2*N-1:0]   acc_nxt;
  logic [2*N-1:0]   prod;
  logic             last;

  always_comb begin
    is_smull = (MulOp == 2'b10);
    is_wide  = (MulOp == 2'b01) || (MulOp == 2'b10);
    // |0x80..0| stays 0x80..0 as an unsigned value
    a_mag    = a;
    b_mag    = b;
    if (is_smull && a[N-1]) a_mag = {N{1'b0}} - a;
    if (is_smull && b[N-1]) b_mag = {N{1'b0}} - b;
    acc_nxt  = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
    prod     = acc;
    if (sgn) prod = {2*N{1'b0}} - acc;
    last     = (cnt == CW'(N-1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      sgn      <= 1'b0;
      wide     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Result   <= '0;
      Result2  <= '0;
      MulFlags <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            acc    <= '0;
            mcand  <= {{N{1'b0}}, a_mag};
            mplier <= b_mag;
            cnt    <= '0;
            sgn    <= is_smull & (a[N-1] ^ b[N-1]);
            wide   <= is_wide;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (last) begin
            state <= FIX;
          end else begin
            cnt   <= cnt + CW'(1);
          end
        end
        FIX: begin
          acc    <= prod;
          Result <= prod[N-1:0];
          if (wide) begin
            Result2  <= prod[2*N-1:N];
            MulFlags <= {prod[2*N-1], (prod == '0), 2'b00};
          end else begin
            Result2  <= '0;
            MulFlags <= {prod[N-1], (prod[N-1:0] == '0), 2'b00};
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
